// File: rtl/cva5_fifo_pkg.sv
// Shared sizing helpers for the flexible FIFO and its pointer sub-module.
package cva5_fifo_pkg;

  // Pointer width: enough bits to address DEPTH entries, never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cva5_fifo_flex_if.sv
// Handshake/status bundle between a FIFO and the logic that drives it.
// master = producer/consumer side, slave = the FIFO itself.
interface cva5_fifo_flex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 6
) ();

  logic                                               push;
  logic [DATA_WIDTH-1:0]                              data_in;
  logic                                               pop;
  logic                                               flush;
  logic                                               clear_err;
  logic [DATA_WIDTH-1:0]                              data_out;
  logic                                               valid;
  logic                                               full;
  logic                                               almost_full;
  logic [cva5_fifo_pkg::count_width(FIFO_DEPTH)-1:0]  count;
  logic                                               overflow_err;
  logic                                               underflow_err;

  modport master (
    output push, data_in, pop, flush, clear_err,
    input  data_out, valid, full, almost_full, count, overflow_err, underflow_err
  );

  modport slave (
    input  push, data_in, pop, flush, clear_err,
    output data_out, valid, full, almost_full, count, overflow_err, underflow_err
  );

endinterface

// File: rtl/cva5_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on en, wraps DEPTH-1 -> 0 explicitly,
// clr returns it to 0. With DEPTH=1 the wrap compare is always true,
// so the pointer stays at 0.
module cva5_fifo_wrap_ptr
  import cva5_fifo_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  output logic [ptr_width(DEPTH)-1:0]  value
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] value_reg;
  logic [PTR_W-1:0] value_next;

  // Next pointer: clear dominates, otherwise increment with explicit wrap.
  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (en) begin
      if (value_reg == PTR_W'(DEPTH - 1)) begin
        value_next = '0;
      end else begin
        value_next = value_reg + PTR_W'(1);
      end
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/lutram_1w_1r.sv
// Distributed-RAM storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module lutram_1w_1r #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out
);

  logic [WIDTH-1:0] ram [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (wen) begin
      ram[waddr] <= data_in;
    end
  end

  // Zero-latency read so the FIFO head falls through immediately.
  assign data_out = ram[raddr];

endmodule

// File: rtl/cva5_fifo_flex.sv
// First-word-fall-through FIFO of arbitrary depth with flush, occupancy
// count, programmable almost-full and sticky overflow/underflow flags.
// All status outputs decode only the count register, so nothing here is
// combinationally dependent on push or pop.
module cva5_fifo_flex #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 6,
  parameter int ALMOST_FULL_THRESH = FIFO_DEPTH - 1
) (
  input logic             clk,
  input logic             rst,
  cva5_fifo_flex_if.slave fifo
);

  import cva5_fifo_pkg::*;

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = count_width(FIFO_DEPTH);

  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  ovf_reg;
  logic                  udf_reg;
  logic                  is_valid;
  logic                  is_full;
  logic                  pop_ok;
  logic                  acc_push;
  logic                  wr_en;
  logic                  rd_adv;
  logic                  ovf_event;
  logic                  udf_event;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      ptr_span;
  logic [CNT_W-1:0]      span_expected;

  assign is_valid = (count_reg != '0);
  assign is_full  = (count_reg == CNT_W'(FIFO_DEPTH));

  // A pop frees a slot in the same cycle, so a push at full is still
  // accepted alongside it; flush swallows both without side effects.
  assign pop_ok    = fifo.pop & is_valid;
  assign acc_push  = fifo.push & (~is_full | pop_ok);
  assign wr_en     = acc_push & ~fifo.flush;
  assign rd_adv    = pop_ok & ~fifo.flush;
  assign ovf_event = fifo.push & is_full & ~pop_ok & ~fifo.flush;
  assign udf_event = fifo.pop & ~is_valid & ~fifo.flush;

  cva5_fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .en    (wr_en),
    .clr   (fifo.flush),
    .value (wptr)
  );

  cva5_fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .en    (rd_adv),
    .clr   (fifo.flush),
    .value (rptr)
  );

  lutram_1w_1r #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_storage (
    .clk      (clk),
    .waddr    (wptr),
    .raddr    (rptr),
    .wen      (wr_en),
    .data_in  (fifo.data_in),
    .data_out (rd_data)
  );

  // Occupancy update: flush empties, otherwise net of accepted push and pop.
  always_comb begin
    count_next = count_reg;
    if (fifo.flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(acc_push) - CNT_W'(pop_ok);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Sticky error flags: a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (ovf_event) begin
        ovf_reg <= 1'b1;
      end else if (fifo.clear_err) begin
        ovf_reg <= 1'b0;
      end
      if (udf_event) begin
        udf_reg <= 1'b1;
      end else if (fifo.clear_err) begin
        udf_reg <= 1'b0;
      end
    end
  end

  assign fifo.data_out      = rd_data;
  assign fifo.valid         = is_valid;
  assign fifo.full          = is_full;
  assign fifo.almost_full   = (count_reg >= CNT_W'(ALMOST_FULL_THRESH));
  assign fifo.count         = count_reg;
  assign fifo.overflow_err  = ovf_reg;
  assign fifo.underflow_err = udf_reg;

  // Pointer distance modulo depth; equals count except at empty/full,
  // where the pointers coincide.
  always_comb begin
    ptr_span = '0;
    if (wptr >= rptr) begin
      ptr_span = CNT_W'(wptr) - CNT_W'(rptr);
    end else begin
      ptr_span = CNT_W'(FIFO_DEPTH) + CNT_W'(wptr) - CNT_W'(rptr);
    end
    span_expected = is_full ? '0 : count_reg;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_reg <= CNT_W'(FIFO_DEPTH));

  a_full_implies_af: assert property (@(posedge clk) disable iff (!rst)
    is_full |-> fifo.almost_full);

  a_ptr_vs_count: assert property (@(posedge clk) disable iff (!rst)
    ptr_span == span_expected);

endmodule

// File: tb/tb_cva5_fifo_flex.sv
// Self-checking bench for cva5_fifo_flex: a queue-based model of the
// depth-6 FIFO is compared every cycle, with directed literal checks on
// depth-6, depth-1 and depth-5 instances.
module tb_cva5_fifo_flex;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cva5_fifo_flex_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(6)) f6 ();
  cva5_fifo_flex_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(1)) f1 ();
  cva5_fifo_flex_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(5)) f5 ();

  cva5_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(6), .ALMOST_FULL_THRESH(5)) dut6 (
    .clk(clk), .rst(rst), .fifo(f6)
  );
  cva5_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(1), .ALMOST_FULL_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .fifo(f1)
  );
  cva5_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .fifo(f5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the depth-6 instance: a queue plus two flags.
  logic [DW-1:0] m_q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (f6.flush) begin
      m_q.delete();
    end else begin
      int  sz;
      bit  popped;
      bit  ov;
      bit  ud;
      sz     = m_q.size();
      popped = f6.pop && (sz > 0);
      ov     = f6.push && (sz == 6) && !popped;
      ud     = f6.pop && (sz == 0);
      if (popped) void'(m_q.pop_front());
      if (f6.push && !ov) m_q.push_back(f6.data_in);
      m_ovf = ov ? 1'b1 : (f6.clear_err ? 1'b0 : m_ovf);
      m_udf = ud ? 1'b1 : (f6.clear_err ? 1'b0 : m_udf);
    end
  end

  // Every-cycle comparison of the depth-6 DUT against the model.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("m_count", 32'(f6.count), 32'(m_q.size()));
      check("m_valid", 32'(f6.valid), 32'(m_q.size() != 0));
      check("m_full", 32'(f6.full), 32'(m_q.size() == 6));
      check("m_almost_full", 32'(f6.almost_full), 32'(m_q.size() >= 5));
      check("m_overflow_err", 32'(f6.overflow_err), 32'(m_ovf));
      check("m_underflow_err", 32'(f6.underflow_err), 32'(m_udf));
      if (m_q.size() != 0) check("m_data_out", 32'(f6.data_out), 32'(m_q[0]));
    end
  end

  // One transaction on the depth-6 instance, then inputs return to idle.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit po,
                      input bit fl, input bit ce);
    f6.push = p; f6.data_in = d; f6.pop = po; f6.flush = fl; f6.clear_err = ce;
    @(posedge clk);
    #1;
    $display("[TB] push=%0b din=0x%02h pop=%0b flush=%0b clr=%0b -> count=%0d valid=%0b head=0x%02h ovf=%0b udf=%0b",
             p, d, po, fl, ce, f6.count, f6.valid, f6.data_out, f6.overflow_err, f6.underflow_err);
    f6.push = 1'b0; f6.pop = 1'b0; f6.flush = 1'b0; f6.clear_err = 1'b0;
  endtask

  task automatic idle_small();
    f1.push = 1'b0; f1.pop = 1'b0; f1.flush = 1'b0; f1.clear_err = 1'b0;
    f5.push = 1'b0; f5.pop = 1'b0; f5.flush = 1'b0; f5.clear_err = 1'b0;
  endtask

  initial begin
    f6.push = 1'b0; f6.pop = 1'b0; f6.flush = 1'b0; f6.clear_err = 1'b0; f6.data_in = '0;
    f1.data_in = '0; f5.data_in = '0;
    idle_small();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(f6.count), 0);
    check("rst_valid", 32'(f6.valid), 0);
    check("rst_full", 32'(f6.full), 0);
    check("rst_af", 32'(f6.almost_full), 0);
    check("rst_errs", {30'd0, f6.overflow_err, f6.underflow_err}, 0);
    check("rst_d1_full", 32'(f1.full), 0);
    check("rst_d5_count", 32'(f5.count), 0);
    #3 rst = 1'b1;
    chk_en = 1'b1;

    // Basic fall-through ordering.
    step(1, 8'h0A, 0, 0, 0);
    check("push1_valid", 32'(f6.valid), 1);
    check("push1_head", 32'(f6.data_out), 32'h0A);
    step(1, 8'h0B, 0, 0, 0);
    step(1, 8'h0C, 0, 0, 0);
    check("abc_count", 32'(f6.count), 3);
    check("abc_head", 32'(f6.data_out), 32'h0A);
    for (int i = 0; i < 3; i++) begin
      check("abc_pop_head", 32'(f6.data_out), 32'h0A + 32'(i));
      step(0, 8'h00, 1, 0, 0);
    end
    check("abc_empty_valid", 32'(f6.valid), 0);

    // Fill, thresholds and overflow drop.
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'h10 + i), 0, 0, 0);
      if (i == 3) check("fill4_af", 32'(f6.almost_full), 0);
      if (i == 4) check("fill5_af_full", {30'd0, f6.almost_full, f6.full}, 32'b10);
      if (i == 5) check("fill6_full", 32'(f6.full), 1);
    end
    step(1, 8'h99, 0, 0, 0);
    check("ovf_count", 32'(f6.count), 6);
    check("ovf_flag", 32'(f6.overflow_err), 1);
    check("ovf_head", 32'(f6.data_out), 32'h10);
    step(0, 8'h00, 0, 0, 1);
    check("ovf_cleared", 32'(f6.overflow_err), 0);

    // Streaming at full across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      check("stream_head", 32'(f6.data_out), (i < 6) ? 32'h10 + 32'(i) : 32'h20 + 32'(i - 6));
      step(1, 8'(8'h20 + i), 1, 0, 0);
      check("stream_count", 32'(f6.count), 6);
      check("stream_no_ovf", 32'(f6.overflow_err), 0);
    end
    for (int i = 0; i < 6; i++) begin
      check("drain_head", 32'(f6.data_out), 32'h2E + 32'(i));
      step(0, 8'h00, 1, 0, 0);
    end
    check("drain_valid", 32'(f6.valid), 0);

    // Pop on empty with concurrent push.
    step(1, 8'h55, 1, 0, 0);
    check("udf_flag", 32'(f6.underflow_err), 1);
    check("udf_count", 32'(f6.count), 1);
    check("udf_head", 32'(f6.data_out), 32'h55);
    step(0, 8'h00, 0, 0, 1);
    check("udf_cleared", 32'(f6.underflow_err), 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    check("udf_set_beats_clear", 32'(f6.underflow_err), 1);
    step(0, 8'h00, 0, 0, 1);
    check("udf_cleared2", 32'(f6.underflow_err), 0);

    // Flush with push, flush with pop on empty.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0);
    check("pre_flush_count", 32'(f6.count), 4);
    step(1, 8'h66, 0, 1, 0);
    check("flush_count", 32'(f6.count), 0);
    check("flush_valid", 32'(f6.valid), 0);
    check("flush_errs", {30'd0, f6.overflow_err, f6.underflow_err}, 0);
    step(0, 8'h00, 1, 1, 0);
    check("flush_pop_no_udf", 32'(f6.underflow_err), 0);
    step(1, 8'h07, 0, 0, 0);
    check("post_flush_head", 32'(f6.data_out), 32'h07);
    check("post_flush_count", 32'(f6.count), 1);

    // Build occupancy on all three instances, then async reset mid-cycle.
    f1.push = 1'b1; f1.data_in = 8'h31; f5.push = 1'b1; f5.data_in = 8'h51;
    step(1, 8'h08, 0, 0, 0);
    f1.data_in = 8'h32; f5.data_in = 8'h52;
    step(1, 8'h09, 0, 0, 0);
    f1.push = 1'b0; f5.data_in = 8'h53;
    step(0, 8'h00, 0, 0, 0);
    idle_small();
    check("pre_rst_d6_count", 32'(f6.count), 3);
    check("pre_rst_d6_head", 32'(f6.data_out), 32'h07);
    check("pre_rst_d5_count", 32'(f5.count), 3);
    check("pre_rst_d5_head", 32'(f5.data_out), 32'h51);
    check("pre_rst_d5_af", 32'(f5.almost_full), 0);
    check("pre_rst_d1_full_af", {30'd0, f1.full, f1.almost_full}, 32'b11);
    check("pre_rst_d1_head", 32'(f1.data_out), 32'h31);
    check("pre_rst_d1_ovf", 32'(f1.overflow_err), 1);
    #3 rst = 1'b0;
    #1;
    check("arst_d6_status", {f6.valid, f6.full, f6.almost_full, f6.overflow_err, f6.underflow_err}, 0);
    check("arst_d6_count", 32'(f6.count), 0);
    check("arst_d5_status", {f5.valid, f5.full, f5.almost_full, f5.overflow_err, f5.underflow_err}, 0);
    check("arst_d5_count", 32'(f5.count), 0);
    check("arst_d1_status", {f1.valid, f1.full, f1.almost_full, f1.overflow_err, f1.underflow_err}, 0);
    check("arst_d1_count", 32'(f1.count), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_d6_empty", 32'(f6.valid), 0);
    check("post_rst_d1_empty", 32'(f1.valid), 0);
    check("post_rst_d5_empty", 32'(f5.valid), 0);
    f1.push = 1'b1; f1.data_in = 8'h43; f5.push = 1'b1; f5.data_in = 8'h44;
    step(1, 8'h42, 0, 0, 0);
    idle_small();
    check("post_rst_d6_head", 32'(f6.data_out), 32'h42);
    check("post_rst_d6_count", 32'(f6.count), 1);
    check("post_rst_d1_head", 32'(f1.data_out), 32'h43);
    check("post_rst_d1_full", 32'(f1.full), 1);
    check("post_rst_d5_head", 32'(f5.data_out), 32'h44);
    check("post_rst_d5_count", 32'(f5.count), 1);
    f1.pop = 1'b1; f5.pop = 1'b1;
    step(0, 8'h00, 1, 0, 0);
    idle_small();
    check("final_d6_valid", 32'(f6.valid), 0);
    check("final_d1_valid", 32'(f1.valid), 0);
    check("final_d5_valid", 32'(f5.valid), 0);
    check("final_d1_udf", 32'(f1.underflow_err), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
